// File: rtl/rot_reader_pkg.sv
// rot_reader_pkg: shared widths, FSM encoding and rotation direction for the rotating frame reader
package rot_reader_pkg;
    localparam int ADDR_SZ = 20;
    localparam int PIX_W = 24;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    typedef enum logic {ROT_CW = 1'b0, ROT_CCW = 1'b1} rot_t;
endpackage

// File: rtl/rot_addr_gen.sv
// rot_addr_gen: output row/column walk and its CW/CCW mapping to source SRAM addresses
module rot_addr_gen
    import rot_reader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_step,
    input  rot_t               i_dir,
    input  logic [7:0]         i_width_m1,
    input  logic [7:0]         i_height_m1,
    output logic [ADDR_SZ-1:0] o_addr,
    output logic               o_sof,
    output logic               o_eol,
    output logic               o_last
);
    logic [7:0] r_r, r_c, r_w, r_h;
    rot_t       r_dir;
    logic [7:0] w_x, w_y;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r   <= '0;
            r_c   <= '0;
            r_w   <= '0;
            r_h   <= '0;
            r_dir <= ROT_CW;
        end else if (i_load) begin
            r_r   <= '0;
            r_c   <= '0;
            r_w   <= i_width_m1;
            r_h   <= i_height_m1;
            r_dir <= i_dir;
        end else if (i_step && !o_last) begin
            r_c <= o_eol ? 8'd0 : r_c + 8'd1;
            r_r <= o_eol ? r_r + 8'd1 : r_r;
        end
    end
    // counters stop on the last-pixel compare, so 255/255 never wraps
    assign o_eol  = r_c == r_h;
    assign o_sof  = (r_r == 8'd0) && (r_c == 8'd0);
    assign o_last = (r_r == r_w) && o_eol;
    assign w_x    = r_dir == ROT_CCW ? r_w - r_r : r_r;
    assign w_y    = r_dir == ROT_CCW ? r_c : r_h - r_c;
    assign o_addr = {{(ADDR_SZ-16){1'b0}}, w_x, w_y};
endmodule

// File: rtl/rot_reader.sv
// rot_reader: streams a frame out of SRAM rotated 90 degrees, with a 2-entry skid buffer on the pixel port
module rot_reader #(
    parameter int ADDR_SZ = rot_reader_pkg::ADDR_SZ,
    parameter int PIX_W   = rot_reader_pkg::PIX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_dir,
    input  logic [7:0]         i_width_m1,
    input  logic [7:0]         i_height_m1,
    output logic               o_mem_en,
    output logic [ADDR_SZ-1:0] o_mem_addr,
    input  logic [31:0]        i_mem_rdata,
    output logic               o_pix_valid,
    input  logic               i_pix_ready,
    output logic [PIX_W-1:0]   o_pix_data,
    output logic               o_pix_sof,
    output logic               o_pix_eol,
    output logic               o_busy,
    output logic               o_frame_done
);
    import rot_reader_pkg::*;
    state_t               r_state, w_next;
    logic                 r_pend, r_pend_sof, r_pend_eol;
    logic                 r_wp, r_rp;
    logic [1:0]           r_cnt;
    logic [PIX_W+1:0]     r_buf [2];
    logic [PIX_W+1:0]     w_head;
    logic                 w_load, w_pop, w_issue, w_sof, w_eol, w_last;
    logic [ADDR_SZ-1:0]   w_addr;
    logic                 w_unused;
    rot_addr_gen u_gen (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_step      (w_issue),
        .i_dir       (rot_t'(i_dir)),
        .i_width_m1  (i_width_m1),
        .i_height_m1 (i_height_m1),
        .o_addr      (w_addr),
        .o_sof       (w_sof),
        .o_eol       (w_eol),
        .o_last      (w_last)
    );
    assign w_load  = (r_state == S_IDLE) && i_start;
    assign w_pop   = o_pix_valid && i_pix_ready;
    // a pixel leaving this cycle frees its slot, which keeps one read per cycle going
    assign w_issue = (r_state == S_RUN) && (({1'b0, r_cnt} + {2'b0, r_pend}) < (3'd2 + {2'b0, w_pop}));
    always_comb begin
        w_next = r_state;
        w_next = r_state == S_IDLE  ? (i_start ? S_RUN : S_IDLE) :
                 r_state == S_RUN   ? (w_issue && w_last ? S_DRAIN : S_RUN) :
                 r_state == S_DRAIN ? (w_pop && r_cnt == 2'd1 && !r_pend ? S_DONE : S_DRAIN) :
                                      S_IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend     <= 1'b0;
            r_pend_sof <= 1'b0;
            r_pend_eol <= 1'b0;
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_cnt      <= 2'd0;
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
        end else begin
            r_pend     <= w_issue;
            r_pend_sof <= w_sof;
            r_pend_eol <= w_eol;
            if (r_pend) begin
                r_buf[r_wp] <= {r_pend_sof, r_pend_eol, i_mem_rdata[PIX_W-1:0]};
                r_wp        <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_cnt <= r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
        end
    end
    assign w_head       = r_buf[r_rp];
    assign w_unused     = &{1'b0, i_mem_rdata[31:PIX_W]};
    assign o_pix_valid  = r_cnt != 2'd0;
    assign o_pix_data   = w_head[PIX_W-1:0];
    assign o_pix_sof    = o_pix_valid && w_head[PIX_W+1];
    assign o_pix_eol    = o_pix_valid && w_head[PIX_W];
    assign o_mem_en     = w_issue;
    assign o_mem_addr   = w_issue ? w_addr : '0;
    assign o_busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign o_frame_done = r_state == S_DONE;
endmodule

// File: tb/tb_rot_reader.sv
// tb_rot_reader: randomized scoreboard bench for rot_reader against a coordinate-level rotation model
module tb_rot_reader;
    typedef struct packed {logic sof; logic eol; logic [23:0] d;} pix_t;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, dir = 1'b0, pix_ready = 1'b1;
    logic [7:0]  wm1 = '0, hm1 = '0;
    logic        mem_en, pix_valid, pix_sof, pix_eol, busy, frame_done;
    logic [19:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic [23:0] pix_data;
    int          checks = 0, errors = 0;
    pix_t        exp_q[$];
    logic [19:0] addr_q[$];
    bit          mon_en = 0, expect_done = 0, in_frame = 0, mem_mode = 0, held_v = 0;
    pix_t        held, e_m;
    int          done_cnt = 0, pix_cnt = 0, ready_mode = 0, stall_left = 0;

    always #5 clk = ~clk;

    rot_reader dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (start),
        .i_dir        (dir),
        .i_width_m1   (wm1),
        .i_height_m1  (hm1),
        .o_mem_en     (mem_en),
        .o_mem_addr   (mem_addr),
        .i_mem_rdata  (mem_rdata),
        .o_pix_valid  (pix_valid),
        .i_pix_ready  (pix_ready),
        .o_pix_data   (pix_data),
        .o_pix_sof    (pix_sof),
        .o_pix_eol    (pix_eol),
        .o_busy       (busy),
        .o_frame_done (frame_done)
    );

    function automatic logic [31:0] mem_word(input logic [19:0] a, input bit m);
        return m ? (({12'b0, a} * 32'h9E3779B1) ^ 32'h00C0FFEE) : {12'b0, a};
    endfunction

    // synchronous SRAM: word appears the cycle after the strobe
    always @(posedge clk) if (mem_en) mem_rdata <= mem_word(mem_addr, mem_mode);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (stall_left > 0) begin
            pix_ready = 1'b0;
            stall_left--;
        end else begin
            pix_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? ~pix_ready : 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) if (mon_en) begin
        check("busy", {31'b0, busy}, {31'b0, in_frame && !expect_done});
        if (expect_done) begin
            check("frame_done", {31'b0, frame_done}, 32'd1);
            expect_done = 0;
            in_frame = 0;
            done_cnt++;
        end else if (frame_done) begin
            check("spurious_done", {31'b0, frame_done}, 32'd0);
        end
        if (held_v) begin
            check("stall_valid", {31'b0, pix_valid}, 32'd1);
            check("stall_fields", {6'b0, pix_sof, pix_eol, pix_data}, {6'b0, held});
        end
        if (mem_en) begin
            if (addr_q.size() == 0) check("extra_read", {31'b0, mem_en}, 32'd0);
            else check("mem_addr", {12'b0, mem_addr}, {12'b0, addr_q.pop_front()});
        end
        if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_pix", {31'b0, pix_valid}, 32'd0);
            end else begin
                e_m = exp_q.pop_front();
                check("pix", {6'b0, pix_sof, pix_eol, pix_data}, {6'b0, e_m});
                pix_cnt++;
                if (exp_q.size() == 0) expect_done = 1;
            end
            held_v = 0;
        end else if (pix_valid) begin
            held_v = 1;
            held = {pix_sof, pix_eol, pix_data};
        end else begin
            held_v = 0;
        end
    end

    task automatic run_frame(input int w, input int h, input bit d, input int mode, input bit start_mid, input int abort);
        logic [7:0]  x, y;
        logic [19:0] a;
        logic [31:0] wd;
        int          n, target, base;
        for (int r = 0; r <= w; r++)
            for (int c = 0; c <= h; c++) begin
                x = d ? 8'(w - r) : 8'(r);
                y = d ? 8'(c) : 8'(h - c);
                a = {4'b0, x, y};
                wd = mem_word(a, mem_mode);
                addr_q.push_back(a);
                exp_q.push_back({r == 0 && c == 0, c == h, wd[23:0]});
            end
        ready_mode = mode;
        base = pix_cnt;
        target = done_cnt + 1;
        @(posedge clk);
        #1;
        wm1 = 8'(w);
        hm1 = 8'(h);
        dir = d;
        start = 1'b1;
        @(posedge clk);
        in_frame = 1;
        #1;
        start = 1'b0;
        wm1 = 8'($urandom);
        hm1 = 8'($urandom);
        dir = 1'($urandom);
        @(negedge clk);
        check("lat_mem_en", {31'b0, mem_en}, 32'd1);
        @(negedge clk);
        check("lat_wait", {31'b0, pix_valid}, 32'd0);
        @(negedge clk);
        check("lat_valid", {31'b0, pix_valid}, 32'd1);
        if (mode == 1) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            stall_left = 5;
        end
        if (start_mid) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        n = 0;
        if (abort > 0) begin
            while (pix_cnt < base + abort && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("abort_reach", pix_cnt, base + abort);
            @(posedge clk);
            #1 rst = 1'b1;
            mon_en = 0;
            #1;
            check("rst_mem_en", {31'b0, mem_en}, 32'd0);
            check("rst_valid", {31'b0, pix_valid}, 32'd0);
            check("rst_sof_eol", {30'b0, pix_sof, pix_eol}, 32'd0);
            check("rst_busy_done", {30'b0, busy, frame_done}, 32'd0);
            check("rst_addr_data", {mem_addr[7:0], pix_data}, 32'd0);
            exp_q.delete();
            addr_q.delete();
            in_frame = 0;
            expect_done = 0;
            held_v = 0;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            mon_en = 1;
        end else begin
            while (done_cnt < target && n < 40 + 8 * (w + 1) * (h + 1)) begin
                @(posedge clk);
                n++;
            end
            check("frame_end", done_cnt, target);
            check("left_pix", exp_q.size(), 0);
            check("left_addr", addr_q.size(), 0);
            repeat (3) @(posedge clk);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out", {26'b0, mem_en, pix_valid, pix_sof, pix_eol, busy, frame_done}, 32'd0);
        check("reset_bus", {mem_addr[7:0], pix_data}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1;
        run_frame(2, 1, 1'b0, 0, 1'b0, 0);
        run_frame(2, 1, 1'b1, 0, 1'b0, 0);
        run_frame(2, 1, 1'b0, 1, 1'b0, 0);
        run_frame(0, 0, 1'b0, 0, 1'b0, 0);
        run_frame(0, 0, 1'b1, 1, 1'b0, 0);
        run_frame(3, 3, 1'b0, 0, 1'b1, 0);
        run_frame(3, 3, 1'b1, 0, 1'b0, 3);
        run_frame(3, 3, 1'b1, 0, 1'b0, 0);
        mem_mode = 1;
        for (int i = 0; i < 8; i++)
            run_frame($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 2), 1'b0, 0);
        run_frame(255, 0, 1'b0, 2, 1'b0, 0);
        run_frame(0, 255, 1'b1, 0, 1'b0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rot_reader.md
ROT_READER -- requirements
Module: rot_reader

Interface
REQ-001 Parameter: ADDR_SZ, 20, SRAM word address width; address = {4'b0, x[7:0], y[7:0]}.
REQ-002 Parameter: PIX_W, 24, RGB pixel width; the SRAM word is 32 bits and only bits [23:0] are used.
REQ-003 The block SHALL use reset rst (asynchronous, active-high) and clock clk.
REQ-004 clk  in  1  system clock, rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  one-cycle frame request, sampled only in IDLE.
REQ-007 dir  in  1  0 = rotate 90 CW, 1 = rotate 90 CCW; latched at start.
REQ-008 width_m1  in  8  source columns minus 1 (x range); latched at start.
REQ-009 height_m1  in  8  source rows minus 1 (y range); latched at start.
REQ-010 mem_en  out  1  SRAM read strobe.
REQ-011 mem_addr  out  20  SRAM read address.
REQ-012 mem_rdata  in  32  SRAM read data, valid one cycle after mem_en.
REQ-013 pix_valid / pix_ready  out / in  1 / 1  output pixel handshake; a transfer occurs when both are high.
REQ-014 pix_data  out  24  rotated pixel.
REQ-015 pix_sof / pix_eol  out  1 / 1  first pixel of frame / last pixel of an output line (line jump).
REQ-016 busy / frame_done  out  1 / 1  frame in progress / one-cycle pulse after the last transfer.

Function
REQ-017 States: IDLE -> RUN on start; RUN -> DRAIN after the last read is issued; DRAIN -> DONE when the buffer is empty and the last pixel is transferred; DONE -> IDLE after one cycle, with frame_done=1 in DONE.
REQ-018 The output image SHALL have (width_m1+1) lines of (height_m1+1) pixels each; out row r, out column c.
REQ-019 For CW, source x=r and y=height_m1-c; for CCW, source x=width_m1-r and y=c; c increments first, then r.
REQ-020 Reads SHALL issue only when (buffered + in-flight) < 2, using a 2-entry output buffer; sustained throughput SHALL be 1 pixel/cycle while pix_ready=1.
REQ-021 Latency: start sampled at edge E0 -> mem_en high after E0 -> data captured at E2 -> pix_valid high after E2.
REQ-022 pix_data, pix_sof and pix_eol SHALL stay stable while pix_valid=1 and pix_ready=0; pix_valid SHALL never drop without a transfer.
REQ-023 pix_eol SHALL be 1 on c=height_m1; pix_sof SHALL be 1 only on r=0,c=0.
REQ-024 start SHALL be ignored outside IDLE; width_m1, height_m1 and dir changes during a frame SHALL have no effect.
REQ-025 width_m1=height_m1=0 (1x1 image) SHALL produce one pixel with both pix_sof and pix_eol set.
REQ-026 At the 255/255 limits, counters SHALL terminate on compare and SHALL NOT wrap.

Reset
REQ-027 On rst: state=IDLE, buffer empty, and counters cleared.
REQ-028 On rst: mem_en, pix_valid, pix_sof, pix_eol, busy and frame_done are 0; mem_addr and pix_data are 0.
REQ-029 rst mid-frame SHALL abort the frame; the read data returned in the cycle after reset SHALL be discarded.

Structure
REQ-030 A shared package SHALL hold ADDR_SZ, PIX_W, the state encoding typedef and the rotation enum (CW/CCW).
REQ-031 Sub-module rot_addr_gen SHALL hold the r/c counters, the CW/CCW mapping and last-pixel flags; rot_reader SHALL hold the FSM and the 2-entry buffer.

Verification
REQ-032 Memory word = {8'b0, 4'b0, addr[19:0]}, W=3, H=2, dir=0, pix_ready=1: mem_addr = 0x00001, 0x00000, 0x00101, 0x00100, 0x00201, 0x00200; pix_eol on the 2nd, 4th and 6th pixels; frame_done 1 cycle after the last pixel.
REQ-033 Same memory, dir=1: pix_data = 0x000200, 0x000201(eol), 0x000100, 0x000101(eol), 0x000000, 0x000001(eol).
REQ-034 pix_ready toggling 1/0 each cycle plus a random 5-cycle stall: same sequence, no loss or duplication, and fields stable during stalls.
REQ-035 1x1 frame: one pixel 0x000000 with pix_sof=pix_eol=1; busy high for exactly the frame duration.
REQ-036 start pulsed during RUN: ignored, and the frame output is unchanged.
REQ-037 rst after the 3rd pixel of a W=H=4 frame: outputs go 0 immediately; a new start then yields a full 16-pixel frame starting with pix_sof.
